// File: rtl/pio_compute_pkg.sv
// Shared definitions for the HPS operand/result PIO responder.
//   - opcode and FSM state enums
//   - bit positions of the fields carried in the 64-bit PIO words
//   - iteration count of the sequential mul/div core
package pio_compute_pkg;

  localparam int ITERATIONS = 32;

  // operand_b fields
  localparam int REQ_BIT    = 63;
  localparam int OP_MSB     = 62;
  localparam int OP_LSB     = 60;
  // result fields
  localparam int ACK_BIT    = 63;
  localparam int ERR_BIT    = 62;
  localparam int OPECHO_MSB = 58;
  localparam int OPECHO_LSB = 56;
  localparam int CNT_MSB    = 47;
  localparam int CNT_LSB    = 32;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MULLO = 3'd2,
    OP_MULHI = 3'd3,
    OP_DIV   = 3'd4,
    OP_REM   = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that go through the 32-iteration core (when the divisor is non-zero).
  function automatic logic is_muldiv(input opcode_e op);
    return (op == OP_MULLO) || (op == OP_MULHI) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/pio_compute_responder_if.sv
// PIO word bundle between the HPS exports and the compute responder.
//   operand_a/operand_b : HPS -> fabric operand words (req toggle in operand_b[63])
//   result              : fabric -> HPS result word (ack toggle in result[63])
//   busy, done_pulse    : status strobes for LEDs/debug
// master = HPS side, slave = responder.
interface pio_compute_responder_if;
  logic [63:0] operand_a;
  logic [63:0] operand_b;
  logic [63:0] result;
  logic        busy;
  logic        done_pulse;

  modport master (output operand_a, operand_b, input result, busy, done_pulse);
  modport slave  (input operand_a, operand_b, output result, busy, done_pulse);
endinterface

// File: rtl/pio_compute_responder_seq_muldiv_core.sv
// seq_muldiv_core: 32-iteration shift-add multiplier / restoring divider.
//   start    : load a/b and begin (ignored while running is not expected)
//   div_mode : 0 = multiply, 1 = divide (latched at start)
//   done     : high during the cycle whose edge performs the last iteration
//   hi/lo    : multiply -> {hi,lo} = 64-bit product
//              divide   -> lo = quotient, hi = remainder (b must be non-zero)
module seq_muldiv_core
  import pio_compute_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         div_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int IDX_W = $clog2(ITERATIONS);

  logic [W-1:0]     b_q;
  logic             run_q, div_q;
  logic [IDX_W-1:0] idx_q;

  // multiply step: add multiplicand when lsb of multiplier set, then shift right
  logic [W:0] madd;
  // divide step: shift next dividend bit into partial remainder, trial subtract
  logic [W:0] shifted, diff;

  assign madd    = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
  assign shifted = {hi, lo[W-1]};
  assign diff    = shifted - {1'b0, b_q};
  assign done    = run_q && (idx_q == IDX_W'(ITERATIONS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      idx_q <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      div_q <= div_mode;
      idx_q <= '0;
      b_q   <= b;
      hi    <= '0;
      lo    <= a;
    end else if (run_q) begin
      idx_q <= idx_q + 1'b1;
      if (done) run_q <= 1'b0;
      if (div_q) begin
        // remainder < divisor always holds, so diff sign bit means shifted < b
        if (!diff[W]) begin
          hi <= diff[W-1:0];
          lo <= {lo[W-2:0], 1'b1};
        end else begin
          hi <= shifted[W-1:0];
          lo <= {lo[W-2:0], 1'b0};
        end
      end else begin
        {hi, lo} <= {madd, lo[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/pio_compute_responder.sv
// pio_compute_responder: fabric-side responder for the HPS operand/result PIO pair.
// Runs one ALU or iterative mul/div op per toggle-handshake request.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave modport of pio_compute_responder_if
//                operand_a[31:0] A; operand_b[31:0] B, [62:60] opcode, [63] req toggle
//                result[31:0] data, [47:32] cycles, [58:56] op echo, [62] err, [63] ack
// Build option: PIO_RESPONDER_CYCLE_COUNT_EN adds the saturating cycle counter
// reported in result[47:32]; without it that field reads 0.
module pio_compute_responder
  import pio_compute_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              CNT_W     = 16,
  parameter logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
  input logic                    clk,
  input logic                    reset,
  pio_compute_responder_if.slave bus
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  opcode_e           op_q;
  logic              tog_q;
  logic [63:0]       result_q;
  logic              busy_q, done_q;

  opcode_e           op_in;
  logic [DATA_W-1:0] a_in, b_in;
  logic              pending, start;
  logic              core_done;
  logic [DATA_W-1:0] core_hi, core_lo;
  logic [DATA_W-1:0] data_d;
  logic              err_d;
  logic [15:0]       cnt_field;
  logic              unused_bits;

  assign op_in   = opcode_e'(bus.operand_b[OP_MSB:OP_LSB]);
  assign a_in    = bus.operand_a[DATA_W-1:0];
  assign b_in    = bus.operand_b[DATA_W-1:0];
  // Level compare: any req/ack disagreement is an outstanding request.
  assign pending = bus.operand_b[REQ_BIT] != result_q[ACK_BIT];
  assign start   = (state_q == ST_IDLE) && pending && is_muldiv(op_in) && (b_in != '0);
  assign unused_bits = ^{bus.operand_a[63:32], bus.operand_b[59:32]};

  seq_muldiv_core #(.W(DATA_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .div_mode (op_in[2]),  // DIV/REM are 4/5, MULLO/MULHI are 2/3
    .a        (a_in),
    .b        (b_in),
    .done     (core_done),
    .hi       (core_hi),
    .lo       (core_lo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pending) state_d = (is_muldiv(op_in) && (b_in != '0)) ? ST_RUN : ST_DONE;
      ST_RUN:  if (core_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result data from captured operands; core outputs are stable once in DONE.
  always_comb begin
    data_d = '0;
    err_d  = 1'b0;
    case (op_q)
      OP_ADD:   {err_d, data_d} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:   {err_d, data_d} = {1'b0, a_q} - {1'b0, b_q};
      OP_MULLO: data_d = core_lo;
      OP_MULHI: data_d = core_hi;
      OP_DIV: begin
        if (b_q == '0) begin
          data_d = DIV0_QUOT;
          err_d  = 1'b1;
        end else data_d = core_lo;
      end
      OP_REM: begin
        if (b_q == '0) begin
          data_d = a_q;
          err_d  = 1'b1;
        end else data_d = core_hi;
      end
      default: err_d = 1'b1;
    endcase
  end

`ifdef PIO_RESPONDER_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                                          cnt_q <= '0;
    else if ((state_q == ST_IDLE) && pending)           cnt_q <= CNT_W'(1);
    else if ((state_q == ST_RUN) && (cnt_q != '1))      cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_field = 16'(cnt_q);
`else
  assign cnt_field = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      tog_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (pending) begin
          a_q    <= a_in;
          b_q    <= b_in;
          op_q   <= op_in;
          tog_q  <= bus.operand_b[REQ_BIT];
          busy_q <= 1'b1;
        end
        ST_DONE: begin
          // ack travels in the same write as every other field
          result_q <= {tog_q, err_d, 3'b000, op_q, 8'h00, cnt_field, data_d};
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result     = result_q;
  assign bus.busy       = busy_q;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_pio_compute_responder.sv
// Directed bench for pio_compute_responder with a result scoreboard.
module tb_pio_compute_responder;
  import pio_compute_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pio_compute_responder_if bus ();

  pio_compute_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] word;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic req = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic ack);
    logic [31:0] d;
    logic        e;
    logic [63:0] p;
    logic [15:0] c;
    logic        md;
    d  = '0;
    e  = 1'b0;
    p  = {32'h0, a} * {32'h0, b};
    md = (op >= 3'd2) && (op <= 3'd5) && (b != 0);
    case (op)
      3'd0: {e, d} = {1'b0, a} + {1'b0, b};
      3'd1: {e, d} = {1'b0, a} - {1'b0, b};
      3'd2: d = p[31:0];
      3'd3: d = p[63:32];
      3'd4: if (b == 0) begin d = 32'hFFFF_FFFF; e = 1'b1; end else d = a / b;
      3'd5: if (b == 0) begin d = a; e = 1'b1; end else d = a % b;
      default: e = 1'b1;
    endcase
`ifdef PIO_RESPONDER_CYCLE_COUNT_EN
    c = md ? 16'd33 : 16'd1;
`else
    c = 16'd0;
`endif
    return {ack, e, 3'b000, op, 8'h00, c, d};
  endfunction

  // Issue a request; upper operand bits carry junk that must be ignored.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic md;
    @(posedge clk);
    #1;
    req = ~req;
    bus.operand_a = {32'hA5A5_0F0F, a};
    bus.operand_b = {req, op, 28'h5A5_A5A5, b};
    md = (op >= 3'd2) && (op <= 3'd5) && (b != 0);
    e.word = model(op, a, b, req);
    e.lat  = md ? 35 : 3;  // negedges from drive to done: capture + 33 / + 1
    sb.push_back(e);
  endtask

  // Wait for done_pulse (bounded), pop the scoreboard and compare.
  task automatic expect_done(input string tag, input bit chk_lat, input int exp_busy);
    int   n = 0;
    int   bn = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.done_pulse) seen = 1;
      else if (bus.busy) bn++;
    end
    chk({tag, "_seen"}, {63'h0, seen}, 64'h1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, bus.result, e.word);
      if (chk_lat) chk({tag, "_lat"}, 64'(n), 64'(e.lat));
      if (exp_busy >= 0) chk({tag, "_busy"}, 64'(bn), 64'(exp_busy));
      @(negedge clk);
      chk({tag, "_pulse1"}, {63'h0, bus.done_pulse}, 64'h0);
    end
  endtask

  initial begin
    int bn, dn;
    bus.operand_a = '0;
    bus.operand_b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", bus.result, 64'h0);
    chk("rst_busy", {63'h0, bus.busy}, 64'h0);
    chk("rst_done", {63'h0, bus.done_pulse}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ALU ops
    send(3'd0, 32'hFFFF_FFFF, 32'h1);          expect_done("add_carry", 1, 1);
    send(3'd0, 32'h1234_5678, 32'h1111_1111);  expect_done("add", 1, 1);
    send(3'd1, 32'd5, 32'd7);                  expect_done("sub_borrow", 1, 1);
    send(3'd1, 32'd7, 32'd5);                  expect_done("sub", 1, 1);

    // multiply
    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  expect_done("mulhi", 1, 33);
    send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  expect_done("mullo", 1, 33);
    send(3'd3, $urandom, $urandom);            expect_done("mulhi_rnd", 1, 33);
    send(3'd2, $urandom, $urandom);            expect_done("mullo_rnd", 1, 33);

    // divide
    send(3'd4, 32'd100, 32'd7);                expect_done("div", 1, 33);
    send(3'd5, 32'd100, 32'd7);                expect_done("rem", 1, 33);
    send(3'd4, 32'hDEAD_BEEF, 32'd0);          expect_done("div0", 1, 1);
    send(3'd5, 32'd5, 32'd0);                  expect_done("rem0", 1, 1);
    send(3'd4, $urandom, 32'd3 + $urandom_range(0, 9999)); expect_done("div_rnd", 1, 33);
    send(3'd5, $urandom, $urandom);            expect_done("rem_rnd", 1, 33);

    // double toggle while busy: one completion, no restart
    send(3'd2, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #1 bus.operand_b[63] = ~bus.operand_b[63];
    bus.operand_a[31:0] = 32'd77;
    @(posedge clk);
    #1 bus.operand_b[63] = ~bus.operand_b[63];
    expect_done("mullo_dbl", 0, -1);
    bn = 0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      bn += int'(bus.busy);
      dn += int'(bus.done_pulse);
    end
    chk("dbl_no_busy", 64'(bn), 64'h0);
    chk("dbl_no_done", 64'(dn), 64'h0);
    chk("dbl_ack_eq_req", {63'h0, bus.result[63]}, {63'h0, bus.operand_b[63]});

    // single toggle while busy: queued request runs after DONE
    send(3'd2, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    #1 req = ~req;
    bus.operand_a = {32'h0, 32'd3};
    bus.operand_b = {req, 3'd0, 28'h0, 32'd4};
    sb.push_back('{model(3'd0, 32'd3, 32'd4, req), 0});
    expect_done("mullo_first", 0, -1);
    expect_done("add_queued", 0, -1);

    // reset at RUN cycle 10 with req=1 held: rerun from scratch
    if (req) begin
      send(3'd0, 32'd1, 32'd1);
      expect_done("add_align", 1, 1);
    end
    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_result", bus.result, 64'h0);
    chk("midrst_busy", {63'h0, bus.busy}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    expect_done("rerun_mulhi", 1, 33);

    // reserved opcodes
    send(3'd7, 32'h1234, 32'h5678);            expect_done("op7", 1, 1);
    send(3'd6, 32'hFFFF_FFFF, 32'h0);          expect_done("op6", 1, 1);

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
